// File: rtl/hdmi_packet_assembler.sv
// hdmi_packet_assembler
// Serializes one 32-slot HDMI data-island packet per period and appends BCH
// parity computed on the fly: BCH(32,24) over the header and BCH(64,56) over
// each of the four subpackets.
// Ports:
//   clk_pixel          pixel clock, all state on rising edge
//   rst_n              asynchronous active-low reset
//   data_island_period high during packet slots, low elsewhere
//   header[23:0]       packet header HB2:HB1:HB0, bit 0 sent first
//   sub[3:0]           four 56-bit subpackets, bit 0 sent first
//   packet_data[8:0]   bit0 header stream, bits {2i+2,2i+1} subpacket i stream
//   bit_counter[4:0]   live slot counter (slot being sampled)
//   packet_ack[0]      one-cycle pulse while slot-31 bits are on packet_data
module hdmi_packet_assembler (
  input  logic        clk_pixel,
  input  logic        rst_n,
  input  logic        data_island_period,
  input  logic [23:0] header,
  input  logic [55:0] sub [3:0],
  output logic [8:0]  packet_data,
  output logic [4:0]  bit_counter,
  output logic        packet_ack
);

  logic [4:0] cnt_q, cnt_d;
  logic [7:0] hdr_ecc_q, hdr_ecc_d;
  logic [7:0] sub_ecc_q [3:0];
  logic [7:0] sub_ecc_d [3:0];
  logic [8:0] pd_q, pd_d;
  logic       ack_q, ack_d;

  // One LSB-first step of the 1+x^6+x^7+x^8 LFSR.
  function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
    return (e >> 1) ^ (((e[0] ^ b) == 1'b1) ? 8'h83 : 8'h00);
  endfunction

  logic [5:0] lo_idx, hi_idx;
  logic [2:0] hpar_idx;
  logic [2:0] spar_lo, spar_hi;

  always_comb begin
    cnt_d     = '0;
    hdr_ecc_d = '0;
    pd_d      = '0;
    ack_d     = 1'b0;
    for (int unsigned i = 0; i < 4; i++) sub_ecc_d[i] = '0;
    lo_idx    = {cnt_q, 1'b0};
    hi_idx    = {cnt_q, 1'b1};
    // Parity slots 24..31 and 28..31 map onto the low counter bits.
    hpar_idx  = cnt_q[2:0];
    spar_lo   = {cnt_q[1:0], 1'b0};
    spar_hi   = {cnt_q[1:0], 1'b1};

    if (data_island_period) begin
      cnt_d = cnt_q + 5'd1;
      ack_d = (cnt_q == 5'd31);

      if (cnt_q < 5'd24) begin
        pd_d[0]   = header[cnt_q];
        hdr_ecc_d = bch_step(hdr_ecc_q, header[cnt_q]);
      end else begin
        pd_d[0]   = hdr_ecc_q[hpar_idx];
        hdr_ecc_d = hdr_ecc_q;
      end

      for (int unsigned i = 0; i < 4; i++) begin
        if (cnt_q < 5'd28) begin
          pd_d[2*i+1]  = sub[i][lo_idx];
          pd_d[2*i+2]  = sub[i][hi_idx];
          sub_ecc_d[i] = bch_step(bch_step(sub_ecc_q[i], sub[i][lo_idx]),
                                  sub[i][hi_idx]);
        end else begin
          pd_d[2*i+1]  = sub_ecc_q[i][spar_lo];
          pd_d[2*i+2]  = sub_ecc_q[i][spar_hi];
          sub_ecc_d[i] = sub_ecc_q[i];
        end
      end

      // Slot 31 closes the packet: parity restarts clean for the next one.
      if (cnt_q == 5'd31) begin
        hdr_ecc_d = '0;
        for (int unsigned i = 0; i < 4; i++) sub_ecc_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      hdr_ecc_q <= '0;
      pd_q      <= '0;
      ack_q     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) sub_ecc_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hdr_ecc_q <= hdr_ecc_d;
      pd_q      <= pd_d;
      ack_q     <= ack_d;
      for (int unsigned i = 0; i < 4; i++) sub_ecc_q[i] <= sub_ecc_d[i];
    end
  end

  assign packet_data = pd_q;
  assign bit_counter = cnt_q;
  assign packet_ack  = ack_q;

endmodule

// File: tb/tb_hdmi_packet_assembler.sv
module tb_hdmi_packet_assembler;

  logic        clk_pixel = 1'b0;
  logic        rst_n;
  logic        data_island_period;
  logic [23:0] header;
  logic [55:0] sub [3:0];
  logic [8:0]  packet_data;
  logic [4:0]  bit_counter;
  logic        packet_ack;

  hdmi_packet_assembler dut (
    .clk_pixel          (clk_pixel),
    .rst_n              (rst_n),
    .data_island_period (data_island_period),
    .header             (header),
    .sub                (sub),
    .packet_data        (packet_data),
    .bit_counter        (bit_counter),
    .packet_ack         (packet_ack)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    string       name;
    logic [23:0] hdr;
    logic [55:0] s0, s1, s2, s3;
    logic        use_hpar;  // header parity given by hand instead of model
    logic [7:0]  hpar;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int acks  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Serial reference parity over the first n bits of a stream.
  function automatic logic [7:0] bch_ref(input logic [63:0] bits, input int n);
    logic [7:0] e = 8'h00;
    for (int k = 0; k < n; k++) begin
      if ((e[0] ^ bits[k]) == 1'b1) e = (e >> 1) ^ 8'h83;
      else                          e = e >> 1;
    end
    return e;
  endfunction

  task automatic drive(input vec_t v);
    header             = v.hdr;
    sub[0]             = v.s0;
    sub[1]             = v.s1;
    sub[2]             = v.s2;
    sub[3]             = v.s3;
    data_island_period = 1'b1;
  endtask

  function automatic vec_t rnd_vec(input string nm);
    vec_t v;
    logic [63:0] t;
    v.name = nm;
    v.hdr  = 24'($urandom());
    t = {$urandom(), $urandom()}; v.s0 = t[55:0];
    t = {$urandom(), $urandom()}; v.s1 = t[55:0];
    t = {$urandom(), $urandom()}; v.s2 = t[55:0];
    t = {$urandom(), $urandom()}; v.s3 = t[55:0];
    v.use_hpar = 1'b0;
    v.hpar     = 8'h00;
    return v;
  endfunction

  // Called at a negedge; checks all 32 slots, ends at the negedge where
  // slot 31 is visible (upstream may switch inputs right there).
  task automatic run_pkt(input vec_t v);
    logic [31:0] hs;
    logic [63:0] ss [4];
    logic [55:0] sv [4];
    logic [8:0]  e;
    drive(v);
    sv[0] = v.s0; sv[1] = v.s1; sv[2] = v.s2; sv[3] = v.s3;
    hs = {bch_ref({40'd0, v.hdr}, 24), v.hdr};
    if (v.use_hpar) hs[31:24] = v.hpar;
    for (int i = 0; i < 4; i++) ss[i] = {bch_ref({8'd0, sv[i]}, 56), sv[i]};
    for (int c = 0; c < 32; c++) begin
      @(negedge clk_pixel);
      e = '0;
      e[0] = hs[c];
      for (int i = 0; i < 4; i++) begin
        e[2*i+1] = ss[i][2*c];
        e[2*i+2] = ss[i][2*c+1];
      end
      chk($sformatf("%s pd slot%0d", v.name, c), 32'(packet_data), 32'(e));
      chk($sformatf("%s cnt slot%0d", v.name, c), 32'(bit_counter), 32'((c + 1) % 32));
      chk($sformatf("%s ack slot%0d", v.name, c), 32'(packet_ack), 32'(c == 31));
      if (packet_ack) acks++;
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " pd"},  32'(packet_data), 32'd0);
    chk({nm, " cnt"}, 32'(bit_counter), 32'd0);
    chk({nm, " ack"}, 32'(packet_ack),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  vec_t tbl [3];
  vec_t v;
  int   acks0;

  initial begin
    tbl[0] = '{name:"zero", hdr:24'h0, s0:56'h0, s1:56'h0, s2:56'h0, s3:56'h0,
               use_hpar:1'b1, hpar:8'h00};
    tbl[1] = '{name:"hdr1", hdr:24'h000001, s0:56'h0, s1:56'h0, s2:56'h0, s3:56'h0,
               use_hpar:1'b1, hpar:8'h4A};
    tbl[2] = '{name:"sub2", hdr:24'h0, s0:56'h0, s1:56'h0, s2:56'h1, s3:56'h0,
               use_hpar:1'b1, hpar:8'h00};

    rst_n = 1'b0;
    data_island_period = 1'b0;
    header = '0;
    for (int i = 0; i < 4; i++) sub[i] = '0;
    #12;
    chk_idle("reset");
    @(negedge clk_pixel);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_pixel);
    chk_idle("idle");

    for (int t = 0; t < 3; t++) begin
      acks0 = acks;
      run_pkt(tbl[t]);
      chk({tbl[t].name, " ackcount"}, 32'(acks - acks0), 32'd1);
      data_island_period = 1'b0;
      @(negedge clk_pixel);
      chk_idle({tbl[t].name, " after"});
    end

    // Back-to-back packets with no gap.
    acks0 = acks;
    for (int k = 0; k < 4; k++) run_pkt(rnd_vec($sformatf("b2b%0d", k)));
    chk("b2b ackcount", 32'(acks - acks0), 32'd4);
    data_island_period = 1'b0;
    @(negedge clk_pixel);
    chk_idle("b2b end");

    // Abort at slot 15.
    acks0 = acks;
    drive(rnd_vec("abort"));
    repeat (15) @(negedge clk_pixel);
    chk("abort cnt15", 32'(bit_counter), 32'd15);
    data_island_period = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_pixel);
      chk_idle($sformatf("abort low%0d", k));
    end
    run_pkt(rnd_vec("post_abort"));
    chk("abort ackcount", 32'(acks - acks0), 32'd1);

    // Asynchronous reset mid-packet at slot 20.
    data_island_period = 1'b0;
    @(negedge clk_pixel);
    drive(rnd_vec("pre_rst"));
    repeat (20) @(negedge clk_pixel);
    chk("rst cnt20", 32'(bit_counter), 32'd20);
    #2 rst_n = 1'b0;
    #1 chk_idle("async rst");
    @(negedge clk_pixel);
    rst_n = 1'b1;
    run_pkt(rnd_vec("post_rst"));
    data_island_period = 1'b0;
    @(negedge clk_pixel);
    chk_idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
